// File: rtl/fft_bfly_dit_seq.sv
// Sequential radix-2 DIT butterfly (a +/- w*b) on single-precision complex operands,
// sharing one combinational multiplier and one combinational adder under an FSM.

module fp_multiplier_comb (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic               sign_s;
  logic [47:0]        prod_s;
  logic signed [9:0]  exp_s;
  logic [23:0]        man_s;
  logic [24:0]        man_rnd_s;
  logic [22:0]        frac_s;
  logic               guard_s, sticky_s;
  logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;

  // Normalise, round to nearest even, and resolve special operands; subnormals flush to zero
  always_comb begin
    sign_s   = a[31] ^ b[31];
    prod_s   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp_s    = signed'({2'b00, a[30:23]}) + signed'({2'b00, b[30:23]}) - 10'sd127;
    a_zero_s = (a[30:23] == 8'd0);
    b_zero_s = (b[30:23] == 8'd0);
    a_inf_s  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf_s  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan_s  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan_s  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (prod_s[47]) begin
      man_s    = prod_s[47:24];
      guard_s  = prod_s[23];
      sticky_s = |prod_s[22:0];
      exp_s    = exp_s + 10'sd1;
    end else begin
      man_s    = prod_s[46:23];
      guard_s  = prod_s[22];
      sticky_s = |prod_s[21:0];
    end
    man_rnd_s = {1'b0, man_s} + {24'd0, guard_s & (sticky_s | man_s[0])};
    if (man_rnd_s[24]) begin
      frac_s = man_rnd_s[23:1];
      exp_s  = exp_s + 10'sd1;
    end else begin
      frac_s = man_rnd_s[22:0];
    end
    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      y = 32'h7FC0_0000;
    end else if (a_inf_s || b_inf_s) begin
      y = {sign_s, 8'hFF, 23'd0};
    end else if (a_zero_s || b_zero_s) begin
      y = {sign_s, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      y = {sign_s, 8'hFF, 23'd0};
    end else if (exp_s <= 10'sd0) begin
      y = {sign_s, 31'd0};
    end else begin
      y = {sign_s, exp_s[7:0], frac_s};
    end
  end
endmodule

module fp_adder_comb (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0]        big_s, small_s;
  logic [7:0]         diff_s;
  logic [23:0]        man_big_s, man_small_s, man_s;
  logic [50:0]        big_x_s, small_x_s, sum_s, norm_s;
  logic [5:0]         msb_s;
  logic signed [9:0]  exp_s;
  logic [24:0]        man_rnd_s;
  logic [22:0]        frac_s;
  logic               sub_s, guard_s, sticky_s;
  logic               a_inf_s, b_inf_s, a_nan_s, b_nan_s;

  // Align the smaller magnitude under the larger, add or subtract, renormalise and round
  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      big_s   = a;
      small_s = b;
    end else begin
      big_s   = b;
      small_s = a;
    end
    sub_s       = big_s[31] ^ small_s[31];
    man_big_s   = (big_s[30:23] == 8'd0) ? 24'd0 : {1'b1, big_s[22:0]};
    man_small_s = (small_s[30:23] == 8'd0) ? 24'd0 : {1'b1, small_s[22:0]};
    diff_s      = big_s[30:23] - small_s[30:23];
    big_x_s     = {1'b0, man_big_s, 26'd0};
    // Beyond 26 positions the small operand only contributes a sticky bit
    if (diff_s >= 8'd27) begin
      small_x_s = {50'd0, |man_small_s};
    end else begin
      small_x_s = {1'b0, man_small_s, 26'd0} >> diff_s;
    end
    sum_s = sub_s ? (big_x_s - small_x_s) : (big_x_s + small_x_s);
    msb_s = 6'd0;
    for (int i = 0; i < 51; i++) begin
      msb_s = sum_s[i] ? 6'(i) : msb_s;
    end
    norm_s    = sum_s << (6'd50 - msb_s);
    exp_s     = signed'({2'b00, big_s[30:23]}) + signed'({4'b0000, msb_s}) - 10'sd49;
    man_s     = norm_s[50:27];
    guard_s   = norm_s[26];
    sticky_s  = |norm_s[25:0];
    man_rnd_s = {1'b0, man_s} + {24'd0, guard_s & (sticky_s | man_s[0])};
    if (man_rnd_s[24]) begin
      frac_s = man_rnd_s[23:1];
      exp_s  = exp_s + 10'sd1;
    end else begin
      frac_s = man_rnd_s[22:0];
    end
    a_inf_s = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf_s = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan_s = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan_s = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && sub_s)) begin
      y = 32'h7FC0_0000;
    end else if (a_inf_s || b_inf_s) begin
      y = {big_s[31], 8'hFF, 23'd0};
    end else if (sum_s == 51'd0) begin
      y = {a[31] & b[31], 31'd0};
    end else if (exp_s >= 10'sd255) begin
      y = {big_s[31], 8'hFF, 23'd0};
    end else if (exp_s <= 10'sd0) begin
      y = {big_s[31], 31'd0};
    end else begin
      y = {big_s[31], exp_s[7:0], frac_s};
    end
  end
endmodule

module fft_bfly_dit_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        inv,
  input  logic [31:0] a_re,
  input  logic [31:0] a_im,
  input  logic [31:0] b_re,
  input  logic [31:0] b_im,
  input  logic [31:0] w_re,
  input  logic [31:0] w_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_o_re,
  output logic [31:0] a_o_im,
  output logic [31:0] b_o_re,
  output logic [31:0] b_o_im
);
  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, A0, A1, A2, A3, A4, A5, DONE} state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] a_re_r, a_im_r, b_re_r, b_im_r, w_re_r, w_im_r;
  logic [31:0] p0_r, p1_r, p2_r, p3_r, t_re_r, t_im_r;
  logic [31:0] mul_a_s, mul_b_s, mul_y_s, add_a_s, add_b_s, add_y_s;

  function automatic logic [31:0] fneg(input logic [31:0] x);
    fneg = {~x[31], x[30:0]};
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);

  fp_multiplier_comb u_mul (.a(mul_a_s), .b(mul_b_s), .y(mul_y_s));
  fp_adder_comb      u_add (.a(add_a_s), .b(add_b_s), .y(add_y_s));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state: fixed walk through the compute states, handshakes in IDLE and DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = in_valid ? M0 : IDLE;
      M0:      state_nxt_s = M1;
      M1:      state_nxt_s = M2;
      M2:      state_nxt_s = M3;
      M3:      state_nxt_s = A0;
      A0:      state_nxt_s = A1;
      A1:      state_nxt_s = A2;
      A2:      state_nxt_s = A3;
      A3:      state_nxt_s = A4;
      A4:      state_nxt_s = A5;
      A5:      state_nxt_s = DONE;
      DONE:    state_nxt_s = out_ready ? IDLE : DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand steering into the shared multiplier and adder
  always_comb begin
    mul_a_s = b_re_r;
    mul_b_s = w_re_r;
    add_a_s = p0_r;
    add_b_s = fneg(p1_r);
    case (state_r)
      M1:      begin mul_a_s = b_im_r; mul_b_s = w_im_r; end
      M2:      begin mul_a_s = b_re_r; mul_b_s = w_im_r; end
      M3:      begin mul_a_s = b_im_r; mul_b_s = w_re_r; end
      A1:      begin add_a_s = p2_r;   add_b_s = p3_r; end
      A2:      begin add_a_s = a_re_r; add_b_s = t_re_r; end
      A3:      begin add_a_s = a_im_r; add_b_s = t_im_r; end
      A4:      begin add_a_s = a_re_r; add_b_s = fneg(t_re_r); end
      A5:      begin add_a_s = a_im_r; add_b_s = fneg(t_im_r); end
      default: begin mul_a_s = b_re_r; mul_b_s = w_re_r; end
    endcase
  end

  // Operand capture and per-state result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_re_r <= 32'd0; a_im_r <= 32'd0; b_re_r <= 32'd0; b_im_r <= 32'd0;
      w_re_r <= 32'd0; w_im_r <= 32'd0;
      p0_r   <= 32'd0; p1_r   <= 32'd0; p2_r   <= 32'd0; p3_r   <= 32'd0;
      t_re_r <= 32'd0; t_im_r <= 32'd0;
      a_o_re <= 32'd0; a_o_im <= 32'd0; b_o_re <= 32'd0; b_o_im <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_re_r <= a_re;
            a_im_r <= a_im;
            b_re_r <= b_re;
            b_im_r <= b_im;
            w_re_r <= w_re;
            // Conjugating the twiddle turns the forward butterfly into the inverse one
            w_im_r <= inv ? fneg(w_im) : w_im;
          end
        end
        M0:      p0_r   <= mul_y_s;
        M1:      p1_r   <= mul_y_s;
        M2:      p2_r   <= mul_y_s;
        M3:      p3_r   <= mul_y_s;
        A0:      t_re_r <= add_y_s;
        A1:      t_im_r <= add_y_s;
        A2:      a_o_re <= add_y_s;
        A3:      a_o_im <= add_y_s;
        A4:      b_o_re <= add_y_s;
        A5:      b_o_im <= add_y_s;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_bfly_dit_seq.sv
// Directed bench for fft_bfly_dit_seq: hand-computed butterflies, latency,
// backpressure, mid-operation reset and back-to-back streaming.

module tb_fft_bfly_dit_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        inv = 1'b0;
  logic [31:0] a_re = 32'd0, a_im = 32'd0, b_re = 32'd0, b_im = 32'd0;
  logic [31:0] w_re = 32'd0, w_im = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] a_o_re, a_o_im, b_o_re, b_o_im;

  typedef struct {
    logic [31:0] ar, ai, br, bi, wr, wi;
    logic        iv;
    logic [31:0] xar, xai, xbr, xbi;
  } vec_t;

  vec_t v[3];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc, k_in, k_out, last_cyc;
  logic acc;

  fft_bfly_dit_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_o_re(a_o_re), .a_o_im(a_o_im), .b_o_re(b_o_re), .b_o_im(b_o_im)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input int k);
    a_re = v[k].ar; a_im = v[k].ai; b_re = v[k].br; b_im = v[k].bi;
    w_re = v[k].wr; w_im = v[k].wi; inv = v[k].iv;
  endtask

  task automatic chk_out(input string tag, input int k);
    chk({tag, "_a_o_re"}, a_o_re, v[k].xar);
    chk({tag, "_a_o_im"}, a_o_im, v[k].xai);
    chk({tag, "_b_o_re"}, b_o_re, v[k].xbr);
    chk({tag, "_b_o_im"}, b_o_im, v[k].xbi);
  endtask

  // Count sample points from the accept edge until out_valid, bounded
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic accept(input string tag, input int k);
    apply(k);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic do_op(input string tag, input int k);
    int n;
    accept(tag, k);
    wait_done(n);
    chk({tag, "_latency"}, n, 32'd10);
    chk_out(tag, k);
    @(posedge clk); #1;
    chk({tag, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    v[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000, 32'h3F800000,
             1'b0, 32'hC0400000, 32'h40A00000, 32'h40A00000, 32'hBF800000};
    v[1] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000, 32'h3F800000,
             1'b1, 32'h40A00000, 32'hBF800000, 32'hC0400000, 32'h40A00000};
    v[2] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000, 32'h00000000,
             1'b0, 32'h40800000, 32'h40C00000, 32'hC0000000, 32'hC0000000};

    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_a_o_re", a_o_re, 32'd0);
    chk("rst_b_o_im", b_o_im, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("fwd", 0);
    do_op("inv", 1);
    do_op("unity", 2);

    // Backpressure: hold DONE for 20 cycles while in_valid toggles with other operands
    out_ready = 1'b0;
    accept("bp", 0);
    wait_done(cyc);
    chk("bp_latency", cyc, 32'd10);
    for (int i = 0; i < 20; i++) begin
      apply(2);
      in_valid = i[0];
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk_out("bp_hold", 0);
    end
    // in_valid together with out_ready in DONE: only the output transfer happens
    apply(1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("coll_ovalid", {31'd0, out_valid}, 32'd0);
    chk("coll_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("coll_accept", {31'd0, in_ready}, 32'd0);
    wait_done(cyc);
    chk("coll_latency", cyc, 32'd10);
    chk_out("coll", 1);
    @(posedge clk); #1;

    // Reset during A1
    accept("rmid", 2);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rmid_ovalid", {31'd0, out_valid}, 32'd0);
    chk("rmid_iready", {31'd0, in_ready}, 32'd1);
    chk("rmid_a_o_re", a_o_re, 32'd0);
    chk("rmid_a_o_im", a_o_im, 32'd0);
    chk("rmid_b_o_re", b_o_re, 32'd0);
    chk("rmid_b_o_im", b_o_im, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_rst", 0);

    // Back-to-back: in_valid and out_ready held high across three operand sets
    k_in = 0; k_out = 0; last_cyc = 0; cyc = 0;
    apply(0);
    in_valid = 1'b1;
    while (k_out < 3 && cyc < 60) begin
      acc = in_ready;
      if (out_valid) begin
        chk_out("b2b", k_out);
        if (k_out > 0) chk("b2b_spacing", cyc - last_cyc, 32'd12);
        last_cyc = cyc;
        k_out++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k_in++;
        if (k_in < 3) apply(k_in);
        else in_valid = 1'b0;
      end
    end
    chk("b2b_outputs", k_out, 32'd3);
    chk("b2b_inputs", k_in, 32'd3);
    @(posedge clk); #1;
    chk("b2b_final_idle", {31'd0, in_ready}, 32'd1);
    chk("b2b_final_ovalid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
